// File: rtl/ysyx_25010008_clint_pkg.sv
// rtl/ysyx_25010008_clint_pkg.sv - shared constants and types for the CLINT mtime slave
//
// Contents:
//   CLINT_ADDR_LO / CLINT_ADDR_HI : word addresses of mtime[31:0] / mtime[63:32]
//   RESP_OKAY / RESP_SLVERR       : AXI4-Lite read response encodings
//   clint_state_t                 : read-channel FSM states
//   is_clint_addr()               : address decode helper, also used by the arbiter
package ysyx_25010008_clint_pkg;

  localparam logic [31:0] CLINT_ADDR_LO = 32'h0200_0048;
  localparam logic [31:0] CLINT_ADDR_HI = 32'h0200_004c;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } clint_state_t;

  // True when the address belongs to this slave; the arbiter steers such
  // reads here rather than to the external master port.
  function automatic logic is_clint_addr(input logic [31:0] addr);
    return (addr == CLINT_ADDR_LO) || (addr == CLINT_ADDR_HI);
  endfunction

endpackage

// File: rtl/ysyx_25010008_clint_prescaler.sv
// rtl/ysyx_25010008_clint_prescaler.sv - divides the clock into a one-cycle mtime tick
//
// Parameters:
//   DIV   : tick is asserted once every DIV cycles (DIV >= 1)
// Ports:
//   clock : system clock
//   reset : asynchronous, active-high reset (count returns to 0)
//   tick  : high for one cycle when the count reaches DIV-1; constant 1 when DIV == 1
module ysyx_25010008_clint_prescaler #(
  parameter int DIV = 1
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  generate
    if (DIV <= 1) begin : g_bypass
      // No divider needed: mtime advances every cycle.
      logic unused_clk_rst;
      assign unused_clk_rst = clock ^ reset;
      assign tick = 1'b1;
    end else begin : g_div
      localparam int W = $clog2(DIV);
      localparam logic [W-1:0] LAST = W'(DIV - 1);

      logic [W-1:0] cnt;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + W'(1);
        end
      end

      assign tick = (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/ysyx_25010008_clint_timer.sv
// rtl/ysyx_25010008_clint_timer.sv - free-running 64-bit mtime behind an AXI4-Lite read-only port
//
// Build option: CLINT_SNAPSHOT_EN
//   defined   : a read of ADDR_LO latches mtime[63:32] into a shadow; ADDR_HI returns the shadow
//   undefined : ADDR_HI returns live mtime[63:32], no shadow register
//
// Parameters:
//   ADDR_LO, ADDR_HI : addresses of mtime[31:0] and mtime[63:32]
//   DIV              : mtime increments once every DIV cycles
// Ports:
//   clock, reset     : system clock, asynchronous active-high reset
//   araddr, arvalid  : read address channel from the master
//   arready          : registered; high in IDLE only
//   rdata, rresp     : read data / response, captured at the AR handshake and held
//   rvalid, rready   : read data channel handshake
//   preload          : when high, mtime takes preload_value at the next edge (debug/test load)
//   preload_value    : 64-bit value loaded into mtime
module ysyx_25010008_clint_timer
  import ysyx_25010008_clint_pkg::*;
#(
  parameter logic [31:0] ADDR_LO = CLINT_ADDR_LO,
  parameter logic [31:0] ADDR_HI = CLINT_ADDR_HI,
  parameter int          DIV     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        preload,
  input  logic [63:0] preload_value
);

  clint_state_t state;
  logic [63:0]  mtime;
  logic         tick;
  logic         ar_fire;
  logic [31:0]  hi_value;
  logic [31:0]  rd_data;
  logic [1:0]   rd_resp;

  ysyx_25010008_clint_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // A single 64-bit add keeps the low-to-high carry within one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime <= '0;
    end else if (preload) begin
      mtime <= preload_value;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // arready is only ever high in IDLE, so this is the AR handshake.
  assign ar_fire = arvalid && arready;

`ifdef CLINT_SNAPSHOT_EN
  logic [31:0] shadow_hi;

  // Latching the upper half alongside a LO read makes a LO-then-HI pair
  // return one coherent 64-bit sample even across a carry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_hi <= '0;
    end else if (ar_fire && (araddr == ADDR_LO)) begin
      shadow_hi <= mtime[63:32];
    end
  end

  assign hi_value = shadow_hi;
`else
  assign hi_value = mtime[63:32];
`endif

  // Decode uses the current (pre-increment) mtime, so a read coinciding
  // with a tick returns the old value.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    if (araddr == ADDR_LO) begin
      rd_data = mtime[31:0];
      rd_resp = RESP_OKAY;
    end else if (araddr == ADDR_HI) begin
      rd_data = hi_value;
      rd_resp = RESP_OKAY;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          arready <= 1'b1;
          if (ar_fire) begin
            state   <= RESP;
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rdata   <= rd_data;
            rresp   <= rd_resp;
          end
        end
        RESP: begin
          // rdata/rresp stay put until the master takes the beat.
          if (rready) begin
            state   <= IDLE;
            rvalid  <= 1'b0;
            arready <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          arready <= 1'b0;
          rvalid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25010008_clint_timer.sv
// tb/tb_ysyx_25010008_clint_timer.sv - self-checking bench for the CLINT mtime slave
`timescale 1ns/1ps
module tb_ysyx_25010008_clint_timer;

  localparam logic [31:0] A_LO  = 32'h0200_0048;
  localparam logic [31:0] A_HI  = 32'h0200_004c;
  localparam logic [31:0] A_BAD = 32'h0200_0000;
`ifdef CLINT_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        preload;
  logic [63:0] preload_value;

  logic [31:0] araddr4;
  logic        arvalid4;
  logic        arready4;
  logic        rready4;
  logic [31:0] rdata4;
  logic [1:0]  rresp4;
  logic        rvalid4;

  int checks = 0;
  int errors = 0;

  logic [63:0] model;
  logic [31:0] shadow_m;
  logic [31:0] exp_data[$];
  logic [1:0]  exp_resp[$];

  always #5 clock = ~clock;

  ysyx_25010008_clint_timer dut (
    .clock         (clock),
    .reset         (reset),
    .araddr        (araddr),
    .arvalid       (arvalid),
    .arready       (arready),
    .rready        (rready),
    .rdata         (rdata),
    .rresp         (rresp),
    .rvalid        (rvalid),
    .preload       (preload),
    .preload_value (preload_value)
  );

  ysyx_25010008_clint_timer #(.DIV(4)) dut4 (
    .clock         (clock),
    .reset         (reset),
    .araddr        (araddr4),
    .arvalid       (arvalid4),
    .arready       (arready4),
    .rready        (rready4),
    .rdata         (rdata4),
    .rresp         (rresp4),
    .rvalid        (rvalid4),
    .preload       (1'b0),
    .preload_value (64'd0)
  );

  // Reference mtime for the DIV=1 instance.
  always @(posedge clock or posedge reset) begin
    if (reset) model <= 64'd0;
    else if (preload) model <= preload_value;
    else model <= model + 64'd1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_preload(input logic [63:0] v);
    @(negedge clock);
    preload = 1'b1;
    preload_value = v;
    @(negedge clock);
    preload = 1'b0;
  endtask

  // Issue one AR beat; push the expected beat computed from the model value
  // held during the handshake cycle. Returns at the negedge after handshake.
  task automatic start_read(input logic [31:0] addr);
    int n = 0;
    @(negedge clock);
    while (!arready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("ar_ready_wait", arready, 1);
    araddr  = addr;
    arvalid = 1'b1;
    if (addr == A_LO) begin
      exp_data.push_back(model[31:0]);
      exp_resp.push_back(2'b00);
      shadow_m = model[63:32];
    end else if (addr == A_HI) begin
      exp_data.push_back(SNAP ? shadow_m : model[63:32]);
      exp_resp.push_back(2'b00);
    end else begin
      exp_data.push_back(32'h0);
      exp_resp.push_back(2'b10);
    end
    @(negedge clock);
    arvalid = 1'b0;
  endtask

  task automatic finish_read(input int stall, input string tag);
    logic [31:0] d;
    logic [1:0]  r;
    chk({tag, "_sb_nonempty"}, exp_data.size() != 0, 1);
    if (exp_data.size() != 0) begin
      d = exp_data.pop_front();
      r = exp_resp.pop_front();
      chk({tag, "_rvalid"}, rvalid, 1);
      for (int i = 0; i < stall; i++) begin
        chk({tag, "_stall_rdata"}, rdata, d);
        chk({tag, "_stall_arready"}, arready, 0);
        @(negedge clock);
      end
      chk({tag, "_rdata"}, rdata, d);
      chk({tag, "_rresp"}, rresp, r);
      chk({tag, "_rvalid_held"}, rvalid, 1);
      rready = 1'b1;
      @(negedge clock);
      rready = 1'b0;
      chk({tag, "_rvalid_drop"}, rvalid, 0);
      chk({tag, "_back_idle"}, arready, 1);
    end
  endtask

  initial begin
    reset = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    preload = 1'b0; preload_value = '0; shadow_m = '0;
    araddr4 = '0; arvalid4 = 1'b0; rready4 = 1'b0;

    repeat (3) @(negedge clock);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_arready4", arready4, 0);

    // DIV=4 instance: read LO about 40 cycles after reset release.
    reset = 1'b0;
    @(negedge clock);
    chk("arready_rise", arready, 1);
    repeat (38) @(negedge clock);
    araddr4 = A_LO;
    arvalid4 = 1'b1;
    @(negedge clock);
    arvalid4 = 1'b0;
    chk("div4_rvalid", rvalid4, 1);
    chk("div4_mtime_range", (rdata4 >= 32'd9) && (rdata4 <= 32'd11), 1);
    chk("div4_rresp", rresp4, 0);
    rready4 = 1'b1;
    @(negedge clock);
    rready4 = 1'b0;
    chk("div4_rvalid_drop", rvalid4, 0);

    // Fresh reset for the DIV=1 directed sequence.
    @(negedge clock);
    reset = 1'b1;
    shadow_m = '0;
    @(negedge clock);
    reset = 1'b0;
    repeat (9) @(negedge clock);
    start_read(A_LO);
    finish_read(0, "t1_lo");

    do_preload(64'h0000_0000_FFFF_FFFF);
    start_read(A_HI);
    finish_read(0, "t2_hi");

    do_preload(64'h0000_0000_FFFF_FFFE);
    start_read(A_LO);
    finish_read(5, "t3_lo");
    start_read(A_HI);
    finish_read(0, "t3_hi");

    start_read(A_BAD);
    finish_read(1, "t4_bad");

    do_preload(64'hFFFF_FFFF_FFFF_FFFF);
    start_read(A_LO);
    finish_read(0, "wrap_lo");
    start_read(A_HI);
    finish_read(0, "wrap_hi");

    // Long stall, then reset lands in the middle of RESP.
    start_read(A_LO);
    chk("t5_rvalid", rvalid, 1);
    for (int i = 0; i < 8; i++) begin
      chk("t5_stall_rdata", rdata, exp_data[0]);
      chk("t5_stall_arready", arready, 0);
      @(negedge clock);
    end
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_rvalid", rvalid, 0);
    chk("t5_rst_arready", arready, 0);
    exp_data.delete();
    exp_resp.delete();
    shadow_m = '0;
    @(negedge clock);
    reset = 1'b0;
    start_read(A_LO);
    finish_read(0, "t5_after_rst");
    start_read(A_HI);
    finish_read(0, "t5_after_rst_hi");

    chk("sb_drained", exp_data.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
